// File: rtl/req_rsp_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | req_rsp_arb_pkg: shared defaults and tag sizing for req_rsp_arbiter.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package req_rsp_arb_pkg;

  localparam int unsigned c_N_REQ_DEFAULT           = 4;
  localparam int unsigned c_DATA_WIDTH_DEFAULT      = 32;
  localparam int unsigned c_MAX_OUTSTANDING_DEFAULT = 4;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned tag_width(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_rsp_tag_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | req_rsp_tag_fifo: in-order FIFO of requester tags awaiting responses.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module req_rsp_tag_fifo
  import req_rsp_arb_pkg::*;
#(
  parameter int unsigned DEPTH = c_MAX_OUTSTANDING_DEFAULT,
  parameter int unsigned WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned c_PW = $clog2(DEPTH);

  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // Full blocks push even when a pop happens in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (c_PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/req_rsp_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | req_rsp_arbiter: round-robin N:1 request arbiter with in-order routing. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module req_rsp_arbiter
  import req_rsp_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = c_N_REQ_DEFAULT,
  parameter int unsigned DATA_WIDTH      = c_DATA_WIDTH_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = c_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 up_req_valid,
  output logic [N_REQ-1:0]                 up_req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]      up_req_data,
  output logic [N_REQ-1:0]                 up_rsp_valid,
  input  logic [N_REQ-1:0]                 up_rsp_ready,
  output logic [DATA_WIDTH-1:0]            up_rsp_data,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [DATA_WIDTH-1:0]            req_data,
  input  logic                             rsp_valid,
  output logic                             rsp_ready,
  input  logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_unexpected_rsp
);

  localparam int unsigned c_TW = tag_width(N_REQ);

  logic [c_TW-1:0]       r_last_grant;
  logic                  r_err;
  logic [c_TW-1:0]       w_cand;
  logic [c_TW-1:0]       w_win_idx;
  logic                  w_win_found;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_TW-1:0]       w_head;
  logic [DATA_WIDTH-1:0] w_req_slice [N_REQ];

  // Round-robin search beginning just after the previous winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      w_cand = c_TW'((int'(r_last_grant) + i) % int'(N_REQ));
      if (!w_win_found && up_req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_out_free = !req_valid || req_ready;
  assign w_accept   = reset && w_win_found && w_out_free && !w_full;
  assign w_pop      = rsp_valid && rsp_ready;

  for (genvar k = 0; k < int'(N_REQ); k++) begin : g_port
    assign w_req_slice[k]  = up_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign up_req_ready[k] = w_accept && (w_win_idx == c_TW'(k));
    assign up_rsp_valid[k] = reset && rsp_valid && !w_empty && (w_head == c_TW'(k));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_grant <= c_TW'(N_REQ - 1);
    end else if (w_accept) begin
      r_last_grant <= w_win_idx;
    end
  end

  // Output register only advances once the downstream slot is free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_valid <= 1'b0;
      req_data  <= '0;
    end else if (w_out_free) begin
      req_valid <= w_accept;
      if (w_accept) req_data <= w_req_slice[w_win_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (rsp_valid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  req_rsp_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (c_TW)
  ) u_tag_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_accept),
    .i_push_data (w_win_idx),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (outstanding)
  );

  assign rsp_ready          = reset && !w_empty && up_rsp_ready[w_head];
  assign up_rsp_data        = rsp_data;
  assign err_unexpected_rsp = r_err;

endmodule
`default_nettype wire

// File: tb/tb_req_rsp_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_req_rsp_arbiter: directed scenarios plus randomized model comparison.|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_req_rsp_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    up_req_valid, up_req_ready, up_rsp_valid, up_rsp_ready;
  logic [N*DW-1:0] up_req_data;
  logic [DW-1:0]   up_rsp_data, req_data, rsp_data, tb_rsp_data;
  logic            req_valid, req_ready, rsp_valid, rsp_ready, tb_rsp_valid, lb;
  logic [2:0]      outstanding;
  logic            err;

  int checks = 0;
  int failures = 0;

  assign rsp_valid = lb ? req_valid : tb_rsp_valid;
  assign rsp_data  = lb ? req_data : tb_rsp_data;

  always #5 clock = ~clock;

  req_rsp_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_data(up_req_data),
    .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready), .up_rsp_data(up_rsp_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .outstanding(outstanding), .err_unexpected_rsp(err)
  );

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic clear_inputs();
    up_req_valid = '0; up_req_data = '0; up_rsp_ready = '0;
    req_ready = 1'b0; tb_rsp_valid = 1'b0; tb_rsp_data = '0; lb = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    up_req_valid = 4'hF; tb_rsp_valid = 1'b1; up_rsp_ready = 4'hF; req_ready = 1'b1;
    tick(); tick();
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (req_data !== 32'h0) begin failures++; $display("FAIL reset_req_data got=%h exp=0", req_data); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (up_req_ready !== 4'h0) begin failures++; $display("FAIL reset_up_req_ready got=%b exp=0000", up_req_ready); end
    checks++; if (up_rsp_valid !== 4'h0) begin failures++; $display("FAIL reset_up_rsp_valid got=%b exp=0000", up_rsp_valid); end
    clear_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_loopback();
    do_reset();
    lb = 1'b1; req_ready = 1'b1; up_rsp_ready = 4'hF; up_req_valid = 4'hF;
    for (int k = 0; k < N; k++) up_req_data[k*DW +: DW] = 32'hC0DE_0000 + k;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      checks++; if (up_req_ready !== 4'(1 << (c % N))) begin
        failures++; $display("FAIL loop_grant c=%0d got=%b exp=%b", c, up_req_ready, 4'(1 << (c % N))); end
      if (c > 0) begin
        checks++; if (up_rsp_valid !== 4'(1 << ((c-1) % N))) begin
          failures++; $display("FAIL loop_rsp_valid c=%0d got=%b exp=%b", c, up_rsp_valid, 4'(1 << ((c-1) % N))); end
        checks++; if (up_rsp_data !== 32'hC0DE_0000 + 32'((c-1) % N)) begin
          failures++; $display("FAIL loop_rsp_data c=%0d got=%h exp=%h", c, up_rsp_data, 32'hC0DE_0000 + 32'((c-1) % N)); end
      end
      tick();
    end
    up_req_valid = '0;
    tick(); tick();
    @(negedge clock);
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL loop_drain got=%0d exp=0", outstanding); end
    lb = 1'b0;
  endtask

  task automatic test_req_backpressure();
    do_reset();
    up_req_valid = 4'b0100;
    for (int k = 0; k < N; k++) up_req_data[k*DW +: DW] = 32'h1111_0000 + k;
    up_req_data[2*DW +: DW] = 32'hDEADBEEF;
    @(negedge clock);
    checks++; if (up_req_ready !== 4'b0100) begin failures++; $display("FAIL bp_first_grant got=%b exp=0100", up_req_ready); end
    tick();
    up_req_valid = 4'b1011;
    up_req_data[2*DW +: DW] = 32'h0BAD_0BAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, req_valid); end
      checks++; if (req_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=deadbeef", c, req_data); end
      checks++; if (up_req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, up_req_ready); end
      tick();
    end
    req_ready = 1'b1;
    @(negedge clock);
    checks++; if (up_req_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_grant got=%b exp=1000", up_req_ready); end
    tick();
    @(negedge clock);
    checks++; if (req_data !== 32'h1111_0003 || req_valid !== 1'b1) begin
      failures++; $display("FAIL bp_next_data got=%h/%b exp=11110003/1", req_data, req_valid); end
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL bp_outstanding got=%0d exp=2", outstanding); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    req_ready = 1'b1; up_req_valid = 4'hF; up_rsp_ready = 4'hF;
    for (int c = 0; c < MO; c++) begin
      @(negedge clock);
      checks++; if (up_req_ready !== 4'(1 << c)) begin failures++; $display("FAIL max_grant c=%0d got=%b exp=%b", c, up_req_ready, 4'(1 << c)); end
      tick();
    end
    tick();
    @(negedge clock);
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL max_full got=%0d exp=4", outstanding); end
    checks++; if (up_req_ready !== 4'h0) begin failures++; $display("FAIL max_no_ready got=%b exp=0000", up_req_ready); end
    tick();
    tb_rsp_valid = 1'b1; tb_rsp_data = 32'h5A5A_0000;
    @(negedge clock);
    checks++; if (rsp_ready !== 1'b1 || up_rsp_valid !== 4'b0001) begin
      failures++; $display("FAIL max_rsp got=%b/%b exp=1/0001", rsp_ready, up_rsp_valid); end
    checks++; if (up_req_ready !== 4'h0) begin failures++; $display("FAIL max_no_bypass got=%b exp=0000", up_req_ready); end
    tick();
    tb_rsp_valid = 1'b0;
    @(negedge clock);
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL max_after_pop got=%0d exp=3", outstanding); end
    checks++; if (up_req_ready !== 4'b0001) begin failures++; $display("FAIL max_reaccept got=%b exp=0001", up_req_ready); end
    tick();
    @(negedge clock);
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL max_refill got=%0d exp=4", outstanding); end
  endtask

  task automatic test_unexpected_rsp();
    do_reset();
    tb_rsp_valid = 1'b1; up_rsp_ready = 4'hF;
    @(negedge clock);
    checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL unexp_rsp_ready got=%b exp=0", rsp_ready); end
    checks++; if (up_rsp_valid !== 4'h0) begin failures++; $display("FAIL unexp_up_rsp_valid got=%b exp=0000", up_rsp_valid); end
    tick();
    tb_rsp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL unexp_sticky c=%0d got=%b exp=1", c, err); end
      tick();
    end
    do_reset();
    @(negedge clock);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL unexp_cleared got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_ready = 1'b1; up_req_valid = 4'b0011;
    tick(); tick();
    req_ready = 1'b0; up_req_valid = 4'hF;
    @(negedge clock);
    checks++; if (outstanding !== 3'd2 || req_valid !== 1'b1) begin
      failures++; $display("FAIL mid_setup got=%0d/%b exp=2/1", outstanding, req_valid); end
    tick();
    reset = 1'b0; tb_rsp_valid = 1'b1; up_rsp_ready = 4'hF;
    @(negedge clock);
    checks++; if (up_req_ready !== 4'h0 || up_rsp_valid !== 4'h0) begin
      failures++; $display("FAIL mid_in_reset got=%b/%b exp=0000/0000", up_req_ready, up_rsp_valid); end
    tick();
    tb_rsp_valid = 1'b0;
    @(negedge clock);
    checks++; if (req_valid !== 1'b0 || outstanding !== 3'd0) begin
      failures++; $display("FAIL mid_cleared got=%b/%0d exp=0/0", req_valid, outstanding); end
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (up_req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%b exp=0001", up_req_ready); end
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    req_ready = 1'b1; up_req_valid = 4'b0100;
    tick();
    up_req_valid = '0;
    tick();
    tb_rsp_valid = 1'b1; tb_rsp_data = 32'h0000_1234; up_rsp_ready = 4'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL rbp_ready c=%0d got=%b exp=0", c, rsp_ready); end
      checks++; if (up_rsp_valid !== 4'b0100) begin failures++; $display("FAIL rbp_valid c=%0d got=%b exp=0100", c, up_rsp_valid); end
      checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL rbp_held c=%0d got=%0d exp=1", c, outstanding); end
      tick();
    end
    up_rsp_ready = 4'b0100;
    @(negedge clock);
    checks++; if (rsp_ready !== 1'b1 || up_rsp_data !== 32'h0000_1234) begin
      failures++; $display("FAIL rbp_deliver got=%b/%h exp=1/00001234", rsp_ready, up_rsp_data); end
    tick();
    tb_rsp_valid = 1'b0;
    @(negedge clock);
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rbp_popped got=%0d exp=0", outstanding); end
  endtask

  // Reference model: queue of tags in flight plus the round-robin pointer.
  task automatic test_random();
    int         m_last, win;
    bit         m_ov, m_err, free, can, e_rr;
    logic [DW-1:0] m_od;
    logic [N-1:0]  e_urr, e_urv;
    int         m_q[$];
    do_reset();
    m_last = N - 1; m_ov = 0; m_err = 0; m_od = '0; m_q = {};
    for (int c = 0; c < 400; c++) begin
      up_req_valid = 4'($urandom);
      up_req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_ready    = ($urandom % 4) != 0;
      tb_rsp_valid = ($urandom % 3) != 0;
      tb_rsp_data  = $urandom();
      up_rsp_ready = 4'($urandom) | 4'($urandom);
      @(negedge clock);
      win = -1;
      for (int i = 1; i <= N; i++) begin
        int j;
        j = (m_last + i) % N;
        if (win < 0 && up_req_valid[j]) win = j;
      end
      free  = !m_ov || req_ready;
      can   = free && (m_q.size() < MO) && (win >= 0);
      e_urr = can ? 4'(1 << win) : 4'h0;
      e_rr  = (m_q.size() > 0) && up_rsp_ready[m_q[0]];
      e_urv = (tb_rsp_valid && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'h0;
      checks++; if (up_req_ready !== e_urr) begin failures++; $display("FAIL rnd_up_req_ready c=%0d got=%b exp=%b", c, up_req_ready, e_urr); end
      checks++; if (req_valid !== m_ov) begin failures++; $display("FAIL rnd_req_valid c=%0d got=%b exp=%b", c, req_valid, m_ov); end
      checks++; if (req_data !== m_od) begin failures++; $display("FAIL rnd_req_data c=%0d got=%h exp=%h", c, req_data, m_od); end
      checks++; if (outstanding !== 3'(m_q.size())) begin failures++; $display("FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding, m_q.size()); end
      checks++; if (rsp_ready !== e_rr) begin failures++; $display("FAIL rnd_rsp_ready c=%0d got=%b exp=%b", c, rsp_ready, e_rr); end
      checks++; if (up_rsp_valid !== e_urv) begin failures++; $display("FAIL rnd_up_rsp_valid c=%0d got=%b exp=%b", c, up_rsp_valid, e_urv); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); end
      if (tb_rsp_valid && m_q.size() == 0) m_err = 1;
      if (tb_rsp_valid && e_rr) void'(m_q.pop_front());
      if (can) begin m_q.push_back(win); m_last = win; end
      if (free) begin
        m_ov = can;
        if (can) m_od = up_req_data[win*DW +: DW];
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_loopback();
    test_req_backpressure();
    test_max_outstanding();
    test_unexpected_rsp();
    test_reset_mid();
    test_rsp_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
